// File: rtl/complex_mulp_pipe.sv
// Three-stage pipelined complex multiplier with optional conjugate twiddle,
// round-half-up scaling, output saturation and a saturating clip counter.
module complex_mulp_pipe #(
    parameter int IN_W    = 8,
    parameter int TW_W    = 12,
    parameter int TW_FRAC = 10,
    parameter int OUT_W   = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              conj,
    input  logic [IN_W-1:0]   in_r,
    input  logic [IN_W-1:0]   in_i,
    input  logic [TW_W-1:0]   cos_2p_by,
    input  logic [TW_W-1:0]   sin_2p_by,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_r,
    output logic [OUT_W-1:0]  out_i,
    output logic              out_sat,
    output logic [15:0]       sat_count
);

    localparam int unsigned PW = IN_W + TW_W;
    localparam int unsigned SW = PW + 1;
    localparam int unsigned RW = SW + 1;
    localparam int unsigned WW = RW + OUT_W;

    localparam logic signed [RW-1:0] RND   = RW'(1) << (TW_FRAC - 1);
    localparam logic signed [WW-1:0] ONE_W = WW'(1);
    localparam logic signed [WW-1:0] MAXV  = (ONE_W <<< (OUT_W - 1)) - ONE_W;
    localparam logic signed [WW-1:0] MINV  = -MAXV - ONE_W;

    logic                 adv;
    logic                 v1, v2, v3;
    logic                 conj1;
    logic signed [PW-1:0] p_rc, p_is, p_ic, p_rs;
    logic signed [SW-1:0] pr2, pi2;
    logic [OUT_W-1:0]     or_q, oi_q;
    logic                 sat_q;
    logic [OUT_W:0]       rs_r, rs_i;

    // Returns {clipped, value}: round half-up, drop fraction, clip to OUT_W.
    function automatic logic [OUT_W:0] rnd_sat(input logic signed [SW-1:0] p);
        logic signed [RW-1:0] r;
        logic signed [WW-1:0] w;
        r = (RW'(p) + RND) >>> TW_FRAC;
        w = WW'(r);
        if (w > MAXV)      return {1'b1, MAXV[OUT_W-1:0]};
        else if (w < MINV) return {1'b1, MINV[OUT_W-1:0]};
        else               return {1'b0, w[OUT_W-1:0]};
    endfunction

    assign rs_r = rnd_sat(pr2);
    assign rs_i = rnd_sat(pi2);

    // A sample being discarded by reset is never offered downstream.
    assign out_valid = v3 && !rst;
    assign adv       = !(out_valid && !out_ready);
    assign in_ready  = adv;
    assign out_r     = or_q;
    assign out_i     = oi_q;
    assign out_sat   = sat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
            conj1 <= 1'b0;
            or_q  <= '0;
            oi_q  <= '0;
            sat_q <= 1'b0;
        end else if (adv) begin
            v1    <= in_valid;
            conj1 <= conj;
            p_rc  <= PW'($signed(in_r)) * PW'($signed(cos_2p_by));
            p_is  <= PW'($signed(in_i)) * PW'($signed(sin_2p_by));
            p_ic  <= PW'($signed(in_i)) * PW'($signed(cos_2p_by));
            p_rs  <= PW'($signed(in_r)) * PW'($signed(sin_2p_by));
            v2    <= v1;
            pr2   <= conj1 ? (SW'(p_rc) + SW'(p_is)) : (SW'(p_rc) - SW'(p_is));
            pi2   <= conj1 ? (SW'(p_ic) - SW'(p_rs)) : (SW'(p_rs) + SW'(p_ic));
            v3    <= v2;
            or_q  <= rs_r[OUT_W-1:0];
            oi_q  <= rs_i[OUT_W-1:0];
            sat_q <= rs_r[OUT_W] | rs_i[OUT_W];
        end
    end

    // Counts clipped samples actually handed downstream; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst)
            sat_count <= '0;
        else if (out_valid && out_ready && sat_q && sat_count != 16'hFFFF)
            sat_count <= sat_count + 16'd1;
    end

endmodule

// File: tb/tb_complex_mulp_pipe.sv
// Bench for complex_mulp_pipe (OUT_W=9): directed vector table, backpressure,
// mid-stall reset and a long random run against an arithmetic reference model.
module tb_complex_mulp_pipe;

    localparam int IN_W    = 8;
    localparam int TW_W    = 12;
    localparam int TW_FRAC = 10;
    localparam int OUT_W   = 9;

    logic             clk, rst, in_valid, in_ready, conj;
    logic [IN_W-1:0]  in_r, in_i;
    logic [TW_W-1:0]  cos_2p_by, sin_2p_by;
    logic             out_valid, out_ready, out_sat;
    logic [OUT_W-1:0] out_r, out_i;
    logic [15:0]      sat_count;

    complex_mulp_pipe #(.IN_W(IN_W), .TW_W(TW_W), .TW_FRAC(TW_FRAC), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .conj(conj),
        .in_r(in_r), .in_i(in_i), .cos_2p_by(cos_2p_by), .sin_2p_by(sin_2p_by),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_i(out_i),
        .out_sat(out_sat), .sat_count(sat_count)
    );

    typedef struct { logic cj; int r; int i; int c; int s; int er; int ei; logic es; } vec_t;
    typedef struct { int r; int i; logic s; } exp_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_out = 0;
    int   m_cnt = 0;
    exp_t q[$];
    vec_t tbl[7];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Complex product in plain integer arithmetic, then floor((P + half) / 2^F) and clip.
    function automatic exp_t model(input logic cj, input int r, input int i, input int c, input int s);
        exp_t   e;
        longint pr, pi, half, hi, lo;
        half = longint'(1) <<< (TW_FRAC - 1);
        hi   = (longint'(1) <<< (OUT_W - 1)) - 1;
        lo   = -hi - 1;
        if (!cj) begin
            pr = longint'(r) * c - longint'(i) * s;
            pi = longint'(r) * s + longint'(i) * c;
        end else begin
            pr = longint'(r) * c + longint'(i) * s;
            pi = longint'(i) * c - longint'(r) * s;
        end
        pr = (pr + half) >>> TW_FRAC;
        pi = (pi + half) >>> TW_FRAC;
        e.s = (pr > hi) || (pr < lo) || (pi > hi) || (pi < lo);
        e.r = int'((pr > hi) ? hi : (pr < lo) ? lo : pr);
        e.i = int'((pi > hi) ? hi : (pi < lo) ? lo : pi);
        return e;
    endfunction

    // Scoreboard, sampled on the falling edge where inputs and outputs are settled.
    task automatic monitor();
        logic             prev_stall = 1'b0;
        logic [OUT_W-1:0] pr_q = '0, pi_q = '0;
        logic             ps_q = 1'b0;
        exp_t             e;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_out_valid", longint'(out_valid), 0);
                chk("rst_in_ready", longint'(in_ready), 1);
                q.delete();
                m_cnt = 0;
                prev_stall = 1'b0;
            end else begin
                chk("in_ready_rule", longint'(in_ready), longint'(!(out_valid && !out_ready)));
                chk("sat_count", longint'(sat_count), longint'(m_cnt));
                if (prev_stall) begin
                    chk("hold_valid", longint'(out_valid), 1);
                    chk("hold_r", longint'(out_r), longint'(pr_q));
                    chk("hold_i", longint'(out_i), longint'(pi_q));
                    chk("hold_sat", longint'(out_sat), longint'(ps_q));
                end
                if (out_valid && out_ready) begin
                    chk("out_expected", longint'(q.size() > 0), 1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        chk("out_r", longint'($signed(out_r)), longint'(e.r));
                        chk("out_i", longint'($signed(out_i)), longint'(e.i));
                        chk("out_sat", longint'(out_sat), longint'(e.s));
                        if (e.s && m_cnt != 65535) m_cnt++;
                    end
                    n_out++;
                end
                if (in_valid && in_ready)
                    q.push_back(model(conj, int'($signed(in_r)), int'($signed(in_i)),
                                      int'($signed(cos_2p_by)), int'($signed(sin_2p_by))));
                prev_stall = out_valid && !out_ready;
                pr_q = out_r;
                pi_q = out_i;
                ps_q = out_sat;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_vec(input vec_t v);
        conj      = v.cj;
        in_r      = IN_W'(v.r);
        in_i      = IN_W'(v.i);
        cos_2p_by = TW_W'(v.c);
        sin_2p_by = TW_W'(v.s);
    endtask

    task automatic drive_rand();
        conj      = 1'($urandom);
        in_r      = IN_W'($urandom);
        in_i      = IN_W'($urandom);
        cos_2p_by = TW_W'($urandom);
        sin_2p_by = TW_W'($urandom);
    endtask

    // Drives one sample after a posedge and checks it appears exactly in the third cycle.
    task automatic latency_check(input string tag, input vec_t v);
        drive_vec(v);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_lat1"}, longint'(out_valid), 0);
        @(negedge clk);
        chk({tag, "_lat2"}, longint'(out_valid), 0);
        @(negedge clk);
        chk({tag, "_valid"}, longint'(out_valid), 1);
        chk({tag, "_r"}, longint'($signed(out_r)), longint'(v.er));
        chk({tag, "_i"}, longint'($signed(out_i)), longint'(v.ei));
        chk({tag, "_sat"}, longint'(out_sat), longint'(v.es));
    endtask

    initial begin
        int sent, cyc, base, tbl_sat;

        tbl[0] = '{1'b0,    5,    3,   512, -1024,    6,   -3, 1'b0};
        tbl[1] = '{1'b1,    5,    3,   512, -1024,    0,    7, 1'b0};
        tbl[2] = '{1'b0, -128, -128, -2048, -2048,    0,  255, 1'b1};
        tbl[3] = '{1'b0,  127,    0,  1023,     0,  127,    0, 1'b0};
        tbl[4] = '{1'b0,   -1,   -1,   512,   512,    0,   -1, 1'b0};
        tbl[5] = '{1'b0, -128,    0, -2048,     0,  255,    0, 1'b1};
        tbl[6] = '{1'b1, -128,  127, -2048, -2048,    2, -256, 1'b1};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drive_vec(tbl[0]);
        fork monitor(); join_none

        repeat (3) tick();
        @(negedge clk);
        chk("reset_out_r", longint'(out_r), 0);
        chk("reset_out_i", longint'(out_i), 0);
        chk("reset_out_sat", longint'(out_sat), 0);
        chk("reset_sat_count", longint'(sat_count), 0);
        tick();
        rst = 1'b0;

        tbl_sat = 0;
        foreach (tbl[k]) begin
            latency_check($sformatf("tbl%0d", k), tbl[k]);
            if (tbl[k].es) tbl_sat++;
            @(negedge clk);
            chk($sformatf("tbl%0d_sat_count", k), longint'(sat_count), longint'(tbl_sat));
            tick();
        end

        // Eight back-to-back samples against a 1,0,0,1 out_ready pattern.
        sent = 0;
        cyc  = 0;
        base = n_out;
        while ((n_out - base) < 8 && cyc < 200) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            in_valid  = sent < 8;
            drive_rand();
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_delivered", longint'(n_out - base), 8);

        // Long random run with random gaps and backpressure.
        sent = 0;
        cyc  = 0;
        while (sent < 10000 && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            drive_rand();
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("rand_sent", longint'(sent), 10000);
        cyc = 0;
        while (q.size() != 0 && cyc < 50) begin
            tick();
            cyc++;
        end
        @(negedge clk);
        chk("rand_drained", longint'(q.size()), 0);
        chk("rand_sat_count", longint'(sat_count), longint'(m_cnt));
        chk("rand_clips_seen", longint'(sat_count != 0), 1);
        tick();

        // Reset while three samples are in flight behind a stalled output.
        out_ready = 1'b0;
        repeat (3) begin
            drive_rand();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", longint'(out_valid), 1);
        chk("pre_rst_stalled", longint'(in_ready), 0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("in_rst_valid", longint'(out_valid), 0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", longint'(out_valid), 0);
        chk("post_rst_sat_count", longint'(sat_count), 0);
        @(posedge clk);
        #1;
        latency_check("post_rst", tbl[1]);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
